// File: rtl/cash_pkg.sv
// Shared types and helpers for the second-chance key-array replacement controller.
package cash_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      WRITE  = 2'd2,
      DELETE = 2'd3
   } cash_sc_state_t;

   localparam int CASH_MAX_IDX_W = 8;
   localparam int CASH_MAX_CELLS = 1 << CASH_MAX_IDX_W;

   function automatic int cash_idx_w(input int n);
      return $clog2(n);
   endfunction

   // Callers truncate the result to their own cell count.
   function automatic logic [CASH_MAX_CELLS-1:0] cash_onehot(input logic [CASH_MAX_IDX_W-1:0] idx);
      logic [CASH_MAX_CELLS-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/cash_lowest_set.sv
// Priority encoder returning the lowest set index of a vector plus a found flag.
module cash_lowest_set #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         found
);

   // Scanning downwards lets the lowest set bit overwrite any higher one.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cash_second_chance_ctrl.sv
// Allocation/replacement controller: lowest empty cell first, otherwise a
// second-chance clock sweep over per-cell reference bits.
module cash_second_chance_ctrl
   import cash_pkg::*;
#(
   parameter int NUM_CELLS = 8,
   parameter int IDX_W     = cash_idx_w(NUM_CELLS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_CELLS-1:0] empty_i,
   input  logic [NUM_CELLS-1:0] hit_i,
   input  logic                 lookup_valid_i,
   input  logic                 alloc_req_i,
   output logic                 alloc_ack_o,
   output logic [IDX_W-1:0]     alloc_idx_o,
   input  logic                 del_req_i,
   input  logic [IDX_W-1:0]     del_idx_i,
   output logic                 del_ack_o,
   output logic [NUM_CELLS-1:0] cs_o,
   output logic                 we_o,
   output logic                 del_o,
   output logic                 busy_o
);

   cash_sc_state_t       state_q;
   logic [IDX_W-1:0]     hand_q;
   logic [IDX_W-1:0]     hand_adv;
   logic [IDX_W-1:0]     victim_q;
   logic [IDX_W-1:0]     del_idx_q;
   logic [NUM_CELLS-1:0] ref_q;
   logic [NUM_CELLS-1:0] ref_next;
   logic [IDX_W-1:0]     empty_idx;
   logic                 empty_found;

   cash_lowest_set #(
      .N (NUM_CELLS),
      .W (IDX_W)
   ) u_lowest_empty (
      .vec   (empty_i),
      .idx   (empty_idx),
      .found (empty_found)
   );

   assign hand_adv = (hand_q == IDX_W'(NUM_CELLS - 1)) ? '0 : hand_q + 1'b1;

   // Ordering encodes precedence: lookup hits beat a sweep clear, but lose to
   // the clear issued when a cell is rewritten or deleted.
   always_comb begin
      ref_next = ref_q;
      if (state_q == SCAN && ref_q[hand_q]) ref_next[hand_q] = 1'b0;
      if (lookup_valid_i) ref_next = ref_next | hit_i;
      if (state_q == WRITE) ref_next[victim_q] = 1'b0;
      if (state_q == DELETE) ref_next[del_idx_q] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         hand_q  <= '0;
         ref_q   <= '0;
      end else begin
         ref_q <= ref_next;
         case (state_q)
            IDLE: begin
               if (del_req_i)                       state_q <= DELETE;
               else if (alloc_req_i && empty_found) state_q <= WRITE;
               else if (alloc_req_i)                state_q <= SCAN;
            end
            SCAN: begin
               hand_q <= hand_adv;
               if (!ref_q[hand_q]) state_q <= WRITE;
            end
            WRITE:   state_q <= IDLE;
            DELETE:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Index registers only matter while their state is active, so they carry no reset.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && del_req_i) del_idx_q <= del_idx_i;
      if (state_q == IDLE && !del_req_i && alloc_req_i && empty_found) victim_q <= empty_idx;
      if (state_q == SCAN && !ref_q[hand_q]) victim_q <= hand_q;
   end

   always_comb begin
      alloc_ack_o = (state_q == WRITE);
      alloc_idx_o = (state_q == WRITE) ? victim_q : '0;
      del_ack_o   = (state_q == DELETE);
      we_o        = (state_q == WRITE);
      del_o       = (state_q == DELETE);
      busy_o      = (state_q != IDLE);
      cs_o        = '0;
      if (state_q == WRITE)  cs_o = NUM_CELLS'(cash_onehot(CASH_MAX_IDX_W'(victim_q)));
      if (state_q == DELETE) cs_o = NUM_CELLS'(cash_onehot(CASH_MAX_IDX_W'(del_idx_q)));
   end

endmodule

// File: tb/tb_cash_second_chance_ctrl.sv
// Directed bench for cash_second_chance_ctrl with a simple model of the key cells' empty flags.
module tb_cash_second_chance_ctrl;

   logic       clk;
   logic       reset;
   logic [7:0] empty;
   logic [7:0] hit;
   logic       lookup_valid;
   logic       alloc_req;
   logic       alloc_ack;
   logic [2:0] alloc_idx;
   logic       del_req;
   logic [2:0] del_idx;
   logic       del_ack;
   logic [7:0] cs;
   logic       we;
   logic       del_en;
   logic       busy;
   logic       cells_clear;

   int checks = 0;
   int errors = 0;

   cash_second_chance_ctrl #(.NUM_CELLS(8), .IDX_W(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .empty_i        (empty),
      .hit_i          (hit),
      .lookup_valid_i (lookup_valid),
      .alloc_req_i    (alloc_req),
      .alloc_ack_o    (alloc_ack),
      .alloc_idx_o    (alloc_idx),
      .del_req_i      (del_req),
      .del_idx_i      (del_idx),
      .del_ack_o      (del_ack),
      .cs_o           (cs),
      .we_o           (we),
      .del_o          (del_en),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key cells: written cells become occupied, deleted cells become empty.
   always @(posedge clk) begin
      if (cells_clear) empty <= 8'hFF;
      else if (we) empty <= empty & ~cs;
      else if (del_en) empty <= empty | cs;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_hit(input logic [7:0] h);
      lookup_valid = 1'b1;
      hit = h;
      step();
      lookup_valid = 1'b0;
      hit = 8'h00;
   endtask

   // Raises a request in IDLE, returns cycles to ack (-1 on timeout) and the ack-cycle outputs,
   // then drops the request and steps into the following IDLE cycle.
   task automatic run_alloc(output int lat, output logic [2:0] idx, output logic [7:0] cs_s,
                            output logic we_s);
      lat = -1; idx = '0; cs_s = '0; we_s = 1'b0;
      alloc_req = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (alloc_ack) begin
            lat = n; idx = alloc_idx; cs_s = cs; we_s = we;
            break;
         end
      end
      alloc_req = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1; cells_clear = 1'b1;
      step(); step();
      checks++; if (busy !== 1'b0 || alloc_ack !== 1'b0 || del_ack !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl busy=%b ack=%b dack=%b want 0", busy, alloc_ack, del_ack); end
      checks++; if (cs !== 8'h00 || we !== 1'b0 || del_en !== 1'b0 || alloc_idx !== 3'd0) begin
         errors++; $display("FAIL reset_out cs=%h we=%b del=%b idx=%0d want 0", cs, we, del_en, alloc_idx); end
      checks++; if (dut.hand_q !== 3'd0 || dut.ref_q !== 8'h00) begin
         errors++; $display("FAIL reset_state hand=%0d ref=%h want 0/00", dut.hand_q, dut.ref_q); end
      reset = 1'b0; cells_clear = 1'b0;
      step();
   endtask

   task automatic test_fill();
      int lat; logic [2:0] idx; logic [7:0] c; logic w;
      for (int i = 0; i < 8; i++) begin
         run_alloc(lat, idx, c, w);
         checks++; if (lat !== 1 || idx !== 3'(i)) begin
            errors++; $display("FAIL fill_%0d lat=%0d idx=%0d want lat=1 idx=%0d", i, lat, idx, i); end
         checks++; if (c !== (8'h01 << i) || w !== 1'b1) begin
            errors++; $display("FAIL fill_cs_%0d cs=%h we=%b want %h/1", i, c, w, 8'h01 << i); end
      end
      checks++; if (dut.hand_q !== 3'd0 || empty !== 8'h00) begin
         errors++; $display("FAIL fill_hand hand=%0d empty=%h want 0/00", dut.hand_q, empty); end
   endtask

   task automatic test_full_no_ref();
      int lat; logic [2:0] idx; logic [7:0] c; logic w;
      run_alloc(lat, idx, c, w);
      checks++; if (lat !== 2 || idx !== 3'd0 || c !== 8'h01) begin
         errors++; $display("FAIL full_noref lat=%0d idx=%0d cs=%h want 2/0/01", lat, idx, c); end
      checks++; if (dut.hand_q !== 3'd1) begin
         errors++; $display("FAIL full_noref_hand hand=%0d want 1", dut.hand_q); end
   endtask

   task automatic test_second_chance();
      int lat; logic [2:0] idx; logic [7:0] c; logic w;
      apply_hit(8'h02);
      apply_hit(8'h04);
      checks++; if (dut.ref_q !== 8'h06) begin
         errors++; $display("FAIL sc_refset ref=%h want 06", dut.ref_q); end
      run_alloc(lat, idx, c, w);
      checks++; if (lat !== 4 || idx !== 3'd3 || c !== 8'h08) begin
         errors++; $display("FAIL sc_victim lat=%0d idx=%0d cs=%h want 4/3/08", lat, idx, c); end
      checks++; if (dut.hand_q !== 3'd4 || dut.ref_q !== 8'h00) begin
         errors++; $display("FAIL sc_after hand=%0d ref=%h want 4/00", dut.hand_q, dut.ref_q); end
   endtask

   task automatic test_hit_during_sweep();
      int lat = -1; logic [2:0] idx = '0;
      apply_hit(8'h10);
      apply_hit(8'h20);
      alloc_req = 1'b1;
      // Hand reaches cell 5 in the third cycle; the hit lands on that same cycle.
      for (int n = 1; n <= 20; n++) begin
         step();
         if (n == 2) begin lookup_valid = 1'b1; hit = 8'h20; end
         if (n == 3) begin lookup_valid = 1'b0; hit = 8'h00; end
         if (alloc_ack) begin lat = n; idx = alloc_idx; break; end
      end
      alloc_req = 1'b0; lookup_valid = 1'b0; hit = 8'h00;
      step();
      checks++; if (lat !== 4 || idx !== 3'd6) begin
         errors++; $display("FAIL sweep_hit lat=%0d idx=%0d want 4/6", lat, idx); end
      checks++; if (dut.ref_q !== 8'h20 || dut.hand_q !== 3'd7) begin
         errors++; $display("FAIL sweep_hit_state ref=%h hand=%0d want 20/7", dut.ref_q, dut.hand_q); end
   endtask

   task automatic test_delete_precedence();
      del_req = 1'b1; del_idx = 3'd4; alloc_req = 1'b1;
      step();
      checks++; if (del_ack !== 1'b1 || del_en !== 1'b1 || cs !== 8'h10) begin
         errors++; $display("FAIL del_first dack=%b del=%b cs=%h want 1/1/10", del_ack, del_en, cs); end
      checks++; if (alloc_ack !== 1'b0 || we !== 1'b0) begin
         errors++; $display("FAIL del_excl ack=%b we=%b want 0/0", alloc_ack, we); end
      del_req = 1'b0;
      step();
      checks++; if (empty !== 8'h10 || busy !== 1'b0) begin
         errors++; $display("FAIL del_idle empty=%h busy=%b want 10/0", empty, busy); end
      step();
      checks++; if (alloc_ack !== 1'b1 || alloc_idx !== 3'd4 || cs !== 8'h10 || we !== 1'b1) begin
         errors++; $display("FAIL del_refill ack=%b idx=%0d cs=%h we=%b want 1/4/10/1",
                            alloc_ack, alloc_idx, cs, we); end
      alloc_req = 1'b0;
      step();
      checks++; if (dut.hand_q !== 3'd7 || del_ack !== 1'b0) begin
         errors++; $display("FAIL del_after hand=%0d dack=%b want 7/0", dut.hand_q, del_ack); end
   endtask

   task automatic test_hand_wrap();
      int lat; logic [2:0] idx; logic [7:0] c; logic w;
      run_alloc(lat, idx, c, w);
      checks++; if (lat !== 2 || idx !== 3'd7 || dut.hand_q !== 3'd0) begin
         errors++; $display("FAIL wrap lat=%0d idx=%0d hand=%0d want 2/7/0", lat, idx, dut.hand_q); end
   endtask

   task automatic test_reset_mid_scan();
      int acks = 0;
      int lat; logic [2:0] idx; logic [7:0] c; logic w;
      apply_hit(8'h01);
      apply_hit(8'h02);
      alloc_req = 1'b1;
      step();
      checks++; if (busy !== 1'b1 || alloc_ack !== 1'b0) begin
         errors++; $display("FAIL scan_entry busy=%b ack=%b want 1/0", busy, alloc_ack); end
      reset = 1'b1; alloc_req = 1'b0;
      step();
      checks++; if (busy !== 1'b0 || alloc_ack !== 1'b0 || cs !== 8'h00 || we !== 1'b0 || del_en !== 1'b0) begin
         errors++; $display("FAIL scan_reset_out busy=%b ack=%b cs=%h we=%b del=%b want 0",
                            busy, alloc_ack, cs, we, del_en); end
      checks++; if (dut.hand_q !== 3'd0 || dut.ref_q !== 8'h00) begin
         errors++; $display("FAIL scan_reset_state hand=%0d ref=%h want 0/00", dut.hand_q, dut.ref_q); end
      reset = 1'b0;
      for (int n = 0; n < 4; n++) begin
         step();
         if (alloc_ack) acks++;
      end
      checks++; if (acks !== 0) begin
         errors++; $display("FAIL scan_reset_noack acks=%0d want 0", acks); end
      run_alloc(lat, idx, c, w);
      checks++; if (lat !== 2 || idx !== 3'd0 || dut.hand_q !== 3'd1) begin
         errors++; $display("FAIL post_reset lat=%0d idx=%0d hand=%0d want 2/0/1", lat, idx, dut.hand_q); end
   endtask

   initial begin
      reset = 1'b1; cells_clear = 1'b1;
      hit = 8'h00; lookup_valid = 1'b0;
      alloc_req = 1'b0; del_req = 1'b0; del_idx = 3'd0;
      test_reset();
      test_fill();
      test_full_no_ref();
      test_second_chance();
      test_hit_during_sweep();
      test_delete_precedence();
      test_hand_wrap();
      test_reset_mid_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
